// File: rtl/fifo_flow_pkg.sv
// Shared definitions for the flow-controlled FIFO.
// Contents:
//   DATA_BITS_DEF / ADDR_BITS_DEF : default word width and pointer width
//   ERR_OVF / ERR_UNF             : bit positions inside error_code_out
//   pause_state_e                 : encoding of the pause hysteresis FSM
package fifo_flow_pkg;

    localparam int DATA_BITS_DEF = 10;
    localparam int ADDR_BITS_DEF = 3;

    localparam int ERR_OVF = 0;
    localparam int ERR_UNF = 1;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_PAUSE = 1'b1
    } pause_state_e;

endpackage

// File: rtl/fifo_mem_dp.sv
// Dual-port storage array for the FIFO: one synchronous write port and one
// synchronous read port whose output register only loads on rd_en_i.
// Ports:
//   clk        : clock, rising edge
//   rst_ni     : asynchronous active-low reset of the read data register only
//   wr_en_i    : write strobe
//   wr_addr_i  : write address
//   wr_data_i  : write data
//   rd_en_i    : read strobe (loads rd_data_o on the next edge)
//   rd_addr_i  : read address
//   rd_data_o  : registered read data, holds when rd_en_i is low
module fifo_mem_dp #(
    parameter int DATA_BITS = 10,
    parameter int ADDR_BITS = 3
) (
    input  logic                 clk,
    input  logic                 rst_ni,
    input  logic                 wr_en_i,
    input  logic [ADDR_BITS-1:0] wr_addr_i,
    input  logic [DATA_BITS-1:0] wr_data_i,
    input  logic                 rd_en_i,
    input  logic [ADDR_BITS-1:0] rd_addr_i,
    output logic [DATA_BITS-1:0] rd_data_o
);

    localparam int DEPTH = 1 << ADDR_BITS;

    // Storage carries no reset so it can map onto block or distributed RAM.
    logic [DATA_BITS-1:0] mem_q [DEPTH];
    logic [DATA_BITS-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Read-before-write: a simultaneous read and write to the same slot (the
    // full-FIFO case) returns the old word, which is the oldest entry.
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/fifo_flow_ctrl.sv
// Synchronous FIFO with programmable watermarks, hysteretic pause output for
// upstream flow control, occupancy count and sticky overflow/underflow flags.
// Ports:
//   clk, reset (async active-low)
//   fifo_data_in, fifo_write, fifo_read : producer/consumer requests
//   high_limit, low_limit               : live pause assert/release watermarks
//   error_clr                           : synchronous clear of sticky errors
//   fifo_data_out, fifo_valid_out       : registered read data and its strobe
//   fifo_full_out, fifo_empty_out       : occupancy extremes
//   almost_full_out, almost_empty_out   : combinational watermark compares
//   pause_out                           : hysteretic flow control to producer
//   fifo_count_out                      : occupancy
//   error_fifo_out, error_code_out      : sticky error summary and causes
module fifo_flow_ctrl
    import fifo_flow_pkg::*;
#(
    parameter int DATA_BITS = DATA_BITS_DEF,
    parameter int ADDR_BITS = ADDR_BITS_DEF,
    parameter int CNT_BITS  = ADDR_BITS + 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] fifo_data_in,
    input  logic                 fifo_write,
    input  logic                 fifo_read,
    input  logic [CNT_BITS-1:0]  high_limit,
    input  logic [CNT_BITS-1:0]  low_limit,
    input  logic                 error_clr,
    output logic [DATA_BITS-1:0] fifo_data_out,
    output logic                 fifo_valid_out,
    output logic                 fifo_full_out,
    output logic                 fifo_empty_out,
    output logic                 almost_full_out,
    output logic                 almost_empty_out,
    output logic                 pause_out,
    output logic [CNT_BITS-1:0]  fifo_count_out,
    output logic                 error_fifo_out,
    output logic [1:0]           error_code_out
);

    localparam int                 DEPTH     = 1 << ADDR_BITS;
    localparam logic [CNT_BITS-1:0] DEPTH_CNT = CNT_BITS'(DEPTH);

    logic [ADDR_BITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_BITS-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_BITS-1:0]  count_q, count_d;
    logic [1:0]           err_q, err_d;
    logic                 valid_q;
    pause_state_e         state_q, state_d;

    logic full, empty, wr_ok, rd_ok, ovf, unf;

    assign full  = (count_q == DEPTH_CNT);
    assign empty = (count_q == '0);

    // A write at full is still accepted when a read frees a slot this edge.
    assign wr_ok = fifo_write & (~full | fifo_read);
    assign rd_ok = fifo_read & ~empty;
    assign ovf   = fifo_write & full & ~fifo_read;
    assign unf   = fifo_read & empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_ok) wr_ptr_d = wr_ptr_q + ADDR_BITS'(1);
        if (rd_ok) rd_ptr_d = rd_ptr_q + ADDR_BITS'(1);
        count_d = count_q + CNT_BITS'(wr_ok) - CNT_BITS'(rd_ok);
    end

    // Clear first, then OR in new causes so a same-edge error survives a clear.
    always_comb begin
        err_d = error_clr ? 2'b00 : err_q;
        if (ovf) err_d[ERR_OVF] = 1'b1;
        if (unf) err_d[ERR_UNF] = 1'b1;
    end

    // Pause FSM looks at the post-edge occupancy so pause_out moves on the
    // same edge the count crosses a watermark. The assert test comes first so
    // it wins when overlapping thresholds make both conditions true.
    always_comb begin
        state_d = state_q;
        if (count_d >= high_limit) begin
            state_d = ST_PAUSE;
        end else if (count_d <= low_limit) begin
            state_d = ST_RUN;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 2'b00;
            valid_q  <= 1'b0;
            state_q  <= ST_RUN;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            err_q    <= err_d;
            valid_q  <= rd_ok;
            state_q  <= state_d;
        end
    end

    fifo_mem_dp #(
        .DATA_BITS (DATA_BITS),
        .ADDR_BITS (ADDR_BITS)
    ) u_mem (
        .clk       (clk),
        .rst_ni    (reset),
        .wr_en_i   (wr_ok),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (fifo_data_in),
        .rd_en_i   (rd_ok),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o (fifo_data_out)
    );

    assign fifo_valid_out   = valid_q;
    assign fifo_full_out    = full;
    assign fifo_empty_out   = empty;
    assign almost_full_out  = (count_q >= high_limit);
    assign almost_empty_out = (count_q <= low_limit);
    assign pause_out        = (state_q == ST_PAUSE);
    assign fifo_count_out   = count_q;
    assign error_code_out   = err_q;
    assign error_fifo_out   = |err_q;

endmodule
